foc_sequencer: RTL and testbench
================================

Name: foc_sequencer

Overview:
Per-PWM-period scheduler for the FOC current-loop datapath. On each trigger it runs the stages in a fixed order: ADC sample, Clarke, Park, PI, inverse Park, SVPWM update. Each stage gets a one-cycle enable pulse, and the sequencer waits for that stage's done rising edge before moving on. It also supervises each stage with a timeout, flags trigger overruns and latches faults. It sits between the PWM timer and the transform/controller blocks.

Parameters:
TIMEOUT_CYC, 256, maximum cycles allowed from a stage enable to its done edge before a fault (valid range 2..65535).
CNT_W, 8, width of the overrun counter.

Ports:
iClk  in  1  system clock
iRst_n  in  1  asynchronous active-low reset
iEnable  in  1  level; 1 allows new cycles to start
iTrig  in  1  PWM-period trigger; rising edge starts a cycle
iFault_clr  in  1  single-cycle pulse that clears a latched fault
oAdc_en, oClarke_en, oPark_en, oPi_en, oIpark_en, oSvpwm_en  out  1 each  one-cycle stage start pulses
iAdc_done, iClarke_done, iPark_done, iPi_done, iIpark_done, iSvpwm_done  in  1 each  stage done; the rising edge is what counts
oBusy  out  1  high in every state except IDLE and FAULT
oCycle_done  out  1  one-cycle pulse when a full sequence completes
oOverrun  out  1  one-cycle pulse when a trigger edge arrives while busy
oOverrun_cnt  out  CNT_W  saturating count of overruns
oFault  out  1  sticky stage-timeout flag
oFault_stage  out  3  stage code at the time of the fault: 0=ADC, 1=CLARKE, 2=PARK, 3=PI, 4=IPARK, 5=SVPWM

Behaviour:
- Reset (async, iRst_n=0):
  - state=IDLE.
  - All outputs 0.
  - All edge-detect history registers for iTrig and the done inputs are 0.
  - Timeout counter 0.
  - A reset in the middle of a sequence aborts it immediately. No enables are issued after release until a new trigger edge.
- Edge detection: trig_edge = iTrig & ~trig_q. done_edge(X) = iX_done & ~done_q(X). All history registers are updated every cycle in every state.
- States: IDLE, ADC, CLARKE, PARK, PI, IPARK, SVPWM, FAULT.
- IDLE → ADC when trig_edge & iEnable.
  - On that same clock edge: oAdc_en<=1, timeout counter<=0.
  - iTrig and iEnable are sampled in the cycle the edge is seen.
- Stage advance: in stage state X, a done_edge(X) in cycle t causes the following on the clock edge ending t:
  - state<=next stage;
  - that stage's enable<=1;
  - timeout counter<=0.
  - The next stage's enable is therefore high during cycle t+1. Latency from a done edge to the next enable is 1 cycle.
- Every enable output is high for exactly one cycle.
- The enable pulses are single-cycle, so datapath blocks that edge-detect their enable (for example the Park block) see a clean rising edge on each new period.
- Done edges from any stage other than the current one are ignored. No fault is raised for them.
- SVPWM done_edge → IDLE, with oCycle_done=1 for one cycle.
- Trigger edges:
  - Edge while oBusy=1: oOverrun pulses for 1 cycle, oOverrun_cnt increments and saturates at 2^CNT_W-1. The running sequence is unaffected and the trigger is dropped, not queued.
  - Edge in FAULT: ignored, not counted.
  - Edge in IDLE with iEnable=0: ignored, not counted.
- Timeout:
  - The counter increments every cycle while in a stage state.
  - If it reaches TIMEOUT_CYC-1 with no done edge for that stage → FAULT. At that point oFault<=1 and oFault_stage<=current code.
  - If a done edge arrives in the same cycle the counter reaches the limit, the done wins and the sequence advances.
- FAULT:
  - No enables are issued.
  - On an iFault_clr pulse: oFault<=0, oFault_stage<=0, state → IDLE. A new trigger is required to start again.
  - iFault_clr outside FAULT has no effect.
- iEnable deasserted mid-sequence: the current sequence completes normally, and no new sequence starts while it stays low.
- Best-case period: 6 done edges plus 1 start cycle. oCycle_done follows the SVPWM done edge by 1 cycle.

Test Plan:
- Reset, iEnable=1, iTrig edge at cycle 10, each stub asserts done 3 cycles after its enable → enables appear at cycles 11, 15, 19, 23, 27, 31; oCycle_done=1 at cycle 35; oBusy falls at 35.
- Park stub never asserts done, TIMEOUT_CYC=16 → oFault=1, oFault_stage=2 exactly 15 cycles after oPark_en; no oPi_en. iFault_clr → IDLE; the next trigger runs a full sequence.
- Three trigger edges during a running sequence → three oOverrun pulses, oOverrun_cnt=3, sequence timing unchanged. With CNT_W=2 and 5 overrun edges → count holds at 3.
- Spurious iClarke_done edge while in PI, and iPark_done held high across two periods → no advance from the spurious edge; the held-high Park done does not count as a new edge in period 2, and period 2 times out in PARK.
- iEnable=0 with a trigger edge → nothing happens. iEnable dropped during IPARK → sequence still completes with oCycle_done.
- iRst_n asserted during PI → all outputs 0 asynchronously; after release, no enables until the next trigger edge.

Source files
------------

// File: rtl/foc_sequencer.sv
`default_nettype none
// foc_sequencer: per-PWM-period scheduler for the FOC current loop (ADC, Clarke, Park,
// PI, inverse Park, SVPWM) with per-stage timeout, trigger-overrun count and sticky fault.
module foc_sequencer #(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iEnable,
  input  logic             iTrig,
  input  logic             iFault_clr,
  output logic             oAdc_en,
  output logic             oClarke_en,
  output logic             oPark_en,
  output logic             oPi_en,
  output logic             oIpark_en,
  output logic             oSvpwm_en,
  input  logic             iAdc_done,
  input  logic             iClarke_done,
  input  logic             iPark_done,
  input  logic             iPi_done,
  input  logic             iIpark_done,
  input  logic             iSvpwm_done,
  output logic             oBusy,
  output logic             oCycle_done,
  output logic             oOverrun,
  output logic [CNT_W-1:0] oOverrun_cnt,
  output logic             oFault,
  output logic [2:0]       oFault_stage
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADC    = 3'd1,
    S_CLARKE = 3'd2,
    S_PARK   = 3'd3,
    S_PI     = 3'd4,
    S_IPARK  = 3'd5,
    S_SVPWM  = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [15:0]      TO_LIMIT = 16'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t             state, state_nx;
  logic               trig_q;
  logic [5:0]         done_q;
  logic [5:0]         done_in;
  logic [5:0]         done_edge;
  logic               trig_edge;
  logic [15:0]        tcnt, tcnt_nx, tcnt_inc;
  logic [2:0]         cur_stage;
  logic [5:0]         en, en_nx;
  logic               cycle_done, cycle_done_nx;
  logic               overrun, overrun_nx;
  logic [CNT_W-1:0]   ovr_cnt, ovr_cnt_nx;
  logic               fault, fault_nx;
  logic [2:0]         fault_stage, fault_stage_nx;
  logic               busy;

  // Bit index matches the stage code: 0=ADC ... 5=SVPWM.
  assign done_in   = {iSvpwm_done, iIpark_done, iPi_done, iPark_done, iClarke_done, iAdc_done};
  assign done_edge = done_in & ~done_q;
  assign trig_edge = iTrig & ~trig_q;
  assign busy      = (state != S_IDLE) && (state != S_FAULT);
  assign cur_stage = 3'(state) - 3'd1;
  assign tcnt_inc  = tcnt + 16'd1;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state       <= S_IDLE;
      trig_q      <= 1'b0;
      done_q      <= '0;
      tcnt        <= '0;
      en          <= '0;
      cycle_done  <= 1'b0;
      overrun     <= 1'b0;
      ovr_cnt     <= '0;
      fault       <= 1'b0;
      fault_stage <= '0;
    end else begin
      state       <= state_nx;
      trig_q      <= iTrig;
      done_q      <= done_in;
      tcnt        <= tcnt_nx;
      en          <= en_nx;
      cycle_done  <= cycle_done_nx;
      overrun     <= overrun_nx;
      ovr_cnt     <= ovr_cnt_nx;
      fault       <= fault_nx;
      fault_stage <= fault_stage_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    tcnt_nx        = tcnt;
    en_nx          = '0;
    cycle_done_nx  = 1'b0;
    overrun_nx     = 1'b0;
    ovr_cnt_nx     = ovr_cnt;
    fault_nx       = fault;
    fault_stage_nx = fault_stage;

    // A trigger that lands mid-sequence is dropped, only counted.
    if (busy && trig_edge) begin
      overrun_nx = 1'b1;
      if (ovr_cnt != CNT_MAX) begin
        ovr_cnt_nx = ovr_cnt + 1'b1;
      end
    end

    case (state)
      S_IDLE: begin
        tcnt_nx = '0;
        if (trig_edge && iEnable) begin
          state_nx = S_ADC;
          en_nx[0] = 1'b1;
        end
      end
      S_FAULT: begin
        tcnt_nx = '0;
        if (iFault_clr) begin
          fault_nx       = 1'b0;
          fault_stage_nx = '0;
          state_nx       = S_IDLE;
        end
      end
      default: begin
        // Done edge takes priority over a timeout landing in the same cycle.
        if (done_edge[cur_stage]) begin
          tcnt_nx = '0;
          if (state == S_SVPWM) begin
            state_nx      = S_IDLE;
            cycle_done_nx = 1'b1;
          end else begin
            state_nx                 = state_t'(3'(state) + 3'd1);
            en_nx[cur_stage + 3'd1]  = 1'b1;
          end
        end else if (tcnt_inc == TO_LIMIT) begin
          state_nx       = S_FAULT;
          fault_nx       = 1'b1;
          fault_stage_nx = cur_stage;
          tcnt_nx        = '0;
        end else begin
          tcnt_nx = tcnt_inc;
        end
      end
    endcase
  end

  assign oAdc_en      = en[0];
  assign oClarke_en   = en[1];
  assign oPark_en     = en[2];
  assign oPi_en       = en[3];
  assign oIpark_en    = en[4];
  assign oSvpwm_en    = en[5];
  assign oBusy        = busy;
  assign oCycle_done  = cycle_done;
  assign oOverrun     = overrun;
  assign oOverrun_cnt = ovr_cnt;
  assign oFault       = fault;
  assign oFault_stage = fault_stage;

endmodule
`default_nettype wire

// File: tb/tb_foc_sequencer.sv
`default_nettype none
// Directed bench for foc_sequencer: stage stubs with programmable done latency drive
// sequencing, timeout, overrun, enable gating and mid-sequence reset scenarios.
module tb_foc_sequencer;
  localparam int TO = 16;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic trig = 1'b0;
  logic fault_clr = 1'b0;
  logic [5:0] done_v = '0;
  logic adc_en, clarke_en, park_en, pi_en, ipark_en, svpwm_en;
  logic busy, cycle_done, overrun, fault;
  logic [CW-1:0] ovr_cnt;
  logic [2:0] fault_stage;
  logic [5:0] en_v;

  assign en_v = {svpwm_en, ipark_en, pi_en, park_en, clarke_en, adc_en};

  always #5 clk = ~clk;

  foc_sequencer #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .iClk(clk), .iRst_n(rst_n), .iEnable(enable), .iTrig(trig), .iFault_clr(fault_clr),
    .oAdc_en(adc_en), .oClarke_en(clarke_en), .oPark_en(park_en), .oPi_en(pi_en),
    .oIpark_en(ipark_en), .oSvpwm_en(svpwm_en),
    .iAdc_done(done_v[0]), .iClarke_done(done_v[1]), .iPark_done(done_v[2]),
    .iPi_done(done_v[3]), .iIpark_done(done_v[4]), .iSvpwm_done(done_v[5]),
    .oBusy(busy), .oCycle_done(cycle_done), .oOverrun(overrun), .oOverrun_cnt(ovr_cnt),
    .oFault(fault), .oFault_stage(fault_stage)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dly[6];
  int cd[6];
  bit hold[6];
  int en_cyc[6];
  int en_cnt[6];
  int cd_cnt = 0;
  int cd_cyc = -1;
  int ov_pulses = 0;
  int fault_cyc = -1;
  int en_overlap = 0;
  int saved;
  logic fault_prev = 1'b0;
  logic [5:0] en_prev = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs 1 ns after the edge, then update the stage stubs.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 6; k++) begin
      if (cd[k] > 0) begin
        cd[k]--;
        done_v[k] = (cd[k] == 0) ? 1'b1 : hold[k];
      end else begin
        done_v[k] = hold[k];
      end
      if (en_v[k]) begin
        en_cyc[k] = cyc;
        en_cnt[k]++;
        if (dly[k] > 0) cd[k] = dly[k];
      end
    end
    if (|(en_v & en_prev)) en_overlap++;
    en_prev = en_v;
    if (cycle_done) begin
      cd_cnt++;
      cd_cyc = cyc;
    end
    if (overrun) ov_pulses++;
    if (fault && !fault_prev) fault_cyc = cyc;
    fault_prev = fault;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic trig_pulse();
    trig = 1'b1;
    step();
    trig = 1'b0;
    step();
  endtask

  function automatic int en_total();
    return en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3] + en_cnt[4] + en_cnt[5];
  endfunction

  initial begin
    for (int k = 0; k < 6; k++) begin
      dly[k] = 3; cd[k] = 0; hold[k] = 1'b0; en_cyc[k] = -1; en_cnt[k] = 0;
    end
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", en_v, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {cycle_done, overrun, fault}, 0);
    chk("rst_cnt", ovr_cnt, 0);
    chk("rst_stage", fault_stage, 0);
    rst_n = 1'b1;
    cyc = 0;

    // Full sequence, every stub answers 3 cycles after its enable
    run_to(10);
    trig = 1'b1;
    step();
    trig = 1'b0;
    run_to(34);
    chk("busy_34", busy, 1);
    step();
    chk("cdone_35", cycle_done, 1);
    chk("busy_35", busy, 0);
    for (int k = 0; k < 6; k++) chk($sformatf("en_cyc%0d", k), en_cyc[k], 11 + 4 * k);
    chk("cd_cnt1", cd_cnt, 1);

    // Park never answers: timeout 15 cycles after its enable
    dly[2] = 0;
    run_to(40);
    trig_pulse();
    run_to(70);
    chk("park_en_cyc", en_cyc[2], 49);
    chk("fault_cyc", fault_cyc, 64);
    chk("fault", fault, 1);
    chk("fault_stage", fault_stage, 2);
    chk("fault_busy", busy, 0);
    chk("no_pi_en", en_cnt[3], 1);
    trig_pulse();
    run_to(75);
    chk("fault_trig_adc", en_cnt[0], 2);
    chk("fault_trig_ovr", ovr_cnt, 0);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("clr_fault", fault, 0);
    chk("clr_stage", fault_stage, 0);
    dly[2] = 3;
    run_to(80);
    trig_pulse();
    run_to(106);
    chk("recover_cd", cd_cyc, 105);

    // Overrun: three edges while busy, then five more against a 2-bit counter
    run_to(110);
    trig_pulse();
    repeat (3) trig_pulse();
    run_to(136);
    chk("ovr_pulses3", ov_pulses, 3);
    chk("ovr_cnt3", ovr_cnt, 3);
    chk("ovr_svpwm_cyc", en_cyc[5], 131);
    chk("ovr_cd_cyc", cd_cyc, 135);
    run_to(140);
    trig_pulse();
    repeat (5) trig_pulse();
    run_to(166);
    chk("ovr_pulses8", ov_pulses, 8);
    chk("ovr_sat", ovr_cnt, 3);
    chk("ovr_cd_cyc2", cd_cyc, 165);

    // Spurious Clarke done in PI; Park done then stays high into the next period
    dly[3] = 6;
    run_to(170);
    trig_pulse();
    run_to(182);
    hold[2] = 1'b1;
    run_to(184);
    chk("pi_en_cyc", en_cyc[3], 183);
    done_v[1] = 1'b1;
    run_to(199);
    chk("ipark_cyc", en_cyc[4], 190);
    chk("spur_cd_cyc", cd_cyc, 198);
    saved = en_cnt[3];
    run_to(200);
    trig_pulse();
    run_to(226);
    chk("held_park_en", en_cyc[2], 209);
    chk("held_fault_cyc", fault_cyc, 224);
    chk("held_stage", fault_stage, 2);
    chk("held_no_pi", en_cnt[3], saved);
    hold[2] = 1'b0;
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("clr_fault2", fault, 0);
    dly[3] = 3;

    // Enable gating
    enable = 1'b0;
    saved = en_cnt[0];
    run_to(230);
    trig_pulse();
    run_to(240);
    chk("dis_no_adc", en_cnt[0], saved);
    chk("dis_no_ovr", ov_pulses, 8);
    chk("dis_busy", busy, 0);
    enable = 1'b1;
    run_to(242);
    trig_pulse();
    run_to(259);
    chk("dis_ipark_cyc", en_cyc[4], 259);
    enable = 1'b0;
    run_to(270);
    chk("dis_mid_cd", cd_cyc, 267);
    trig_pulse();
    run_to(280);
    chk("dis_after_adc", en_cnt[0], saved + 1);

    // Asynchronous reset during PI
    enable = 1'b1;
    dly[3] = 6;
    trig_pulse();
    run_to(295);
    chk("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_outs", {en_v, cycle_done, overrun, fault, ovr_cnt, fault_stage}, 0);
    #2;
    rst_n = 1'b1;
    saved = en_total();
    dly[3] = 3;
    run_to(310);
    chk("post_rst_no_en", en_total(), saved);
    trig_pulse();
    run_to(340);
    chk("post_rst_cd", cd_cyc, 335);
    chk("en_single_cycle", en_overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
